// File: rtl/mem_wait_responder.sv
// Unified memory responder with a fixed number of wait states per access.
// Optional MEM_ALIGN_CHECK_EN flags misaligned or out-of-range addresses.
module mem_wait_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_accept;
    logic w_done;
    logic w_fault_in;

    assign w_accept = (r_state == S_IDLE) && req;
    assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_fault_in = (addr[1:0] != 2'b00) ||
                        (addr[ADDR_W-1:IW+2] != '0);
`else
    // Offset and high bits are don't-care: the index wraps modulo DEPTH.
    logic w_unused;
    assign w_unused   = ^{addr[ADDR_W-1:IW+2], addr[1:0]};
    assign w_fault_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (req) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == S_RESP);
        busy  = (r_state != S_IDLE);
`ifdef MEM_ALIGN_CHECK_EN
        err   = ready && r_fault;
`else
        err   = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_we    <= we;
            r_idx   <= addr[IW+1:2];
            r_wdata <= wdata;
            r_fault <= w_fault_in;
        end else if (r_state == S_WAIT) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (r_fault) begin
                r_rdata <= DATA_W'(32'hDEADBEEF);
            end else if (!r_we) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // A reset forces IDLE asynchronously, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (w_done && r_we && !r_fault) r_mem[r_idx] <= r_wdata;
    end

    assign rdata = r_rdata;

endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Unified instruction/data memory responder for the multicycle MIPS core.
- It is the target side of the memory accesses the main controller initiates: instruction fetch, load and store.
- It accepts one request at a time over a req/ready handshake and inserts a configurable number of wait states.
- It completes each access with a one-cycle ready pulse and holds read data stable for the datapath (IR / MDR load).

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 32, byte-address width
- DEPTH, 64, number of words; power of two, >= 2
- LATENCY, 2, wait-state cycles before the access completes; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  access request; sampled only in IDLE
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  ADDR_W  byte address; sampled with req
- wdata  input  DATA_W  write data; sampled with req
- rdata  output  DATA_W  read data; registered
- ready  output  1  one-cycle completion pulse
- busy  output  1  transaction in flight
- err  output  1  access error, valid with ready

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, wait counter = 0, ready = 0, busy = 0, err = 0, rdata = 0.
  - Captured request registers are cleared.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req = 1 at a rising edge, the transaction is accepted: capture we, addr and wdata; load counter = LATENCY-1; go to WAIT; busy <= 1.
  - Call the cycle in which req is high T (the acceptance cycle).
- WAIT:
  - While counter != 0: decrement it.
  - When counter == 0: perform the access, ready <= 1, go to RESP.
- RESP:
  - ready is high for exactly this cycle; busy is still 1.
  - Next edge: ready <= 0, busy <= 0, go to IDLE.
- Timing:
  - ready is high in cycle T+LATENCY+1.
  - busy is high in cycles T+1 through T+LATENCY+1.
  - With req held high continuously, a new transaction is accepted every LATENCY+2 cycles.
- req while busy is ignored. It is not queued and has no effect on the in-flight transaction.
- Read: rdata <= mem[index] on the same edge that raises ready. rdata then holds until the next completed read.
- Write: mem[index] <= captured wdata on the same edge that raises ready. rdata is unchanged.
- Index = captured addr[log2(DEPTH)+1:2].
- Inputs changing after acceptance have no effect, because all request fields are captured at acceptance.
- Reset mid-transaction (rst asserted in WAIT or RESP):
  - The transaction is aborted.
  - A pending write is not committed.
  - No ready pulse is produced after reset releases.
- Simultaneous events: completion and a new req in the RESP cycle → the new req is ignored and must be re-presented in IDLE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A captured address with addr[1:0] != 0, or addr >= DEPTH*4, is an error.
  - On an error: the memory is not written, rdata <= 32'hDEADBEEF (both reads and writes), err <= 1 alongside ready.
  - err clears with ready.
  - Latency is unchanged.
- Not defined:
  - addr[1:0] and bits above the index field are ignored, so the index wraps modulo DEPTH.
  - err is tied to 0.
  - No error logic is synthesized.

Test Plan:
- Defaults (DEPTH=64, LATENCY=2). Reset, then write addr 0x08 data 0x1234ABCD with req in cycle 0 → busy high cycles 1–3, ready high only in cycle 3. Then read 0x08 → rdata = 0x1234ABCD with ready, held after.
- req held high for 12 cycles, alternating read addresses 0x00 and 0x04 → accepts in cycles 0, 4 and 8; exactly 3 ready pulses, in cycles 3, 7 and 11.
- Feature off: write 0x00000100 data 0xCAFEF00D, then read 0x00000000 → rdata = 0xCAFEF00D (wrap). Read 0x00000102 → rdata = 0xCAFEF00D, err = 0.
- Feature on: read 0x06 → ready with err = 1 and rdata = 0xDEADBEEF. Write 0x200 data 0x1 → err = 1. A subsequent read of 0x00 returns its prior value.
- Write 0x10 = 0x11111111 completes. Then write 0x10 = 0xFFFF0000 with rst pulsed in cycle 1 → no ready pulse. A read of 0x10 returns 0x11111111.
- Read 0x0C accepted in cycle 0; req with we = 1 to 0x0C in cycles 1–3 → ignored; memory at 0x0C unchanged; a single ready pulse in cycle 3.
